// File: rtl/entropy_collector.sv
// Excites an array of XOR-latch entropy cells, XOR-reduces their synchronised
// outputs into one bit per excite/relax cycle and packs 32 bits into a word.
module entropy_collector #(
  parameter int NUM_CELLS     = 4,
  parameter int RELAX_CYCLES  = 2,
  parameter int EXCITE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  output logic                 cell_T,
  output logic                 cell_I1,
  output logic                 cell_I2,
  input  logic [NUM_CELLS-1:0] cell_out,
  output logic [31:0]          data_out,
  output logic                 data_valid,
  input  logic                 data_read,
  output logic                 busy,
  output logic [2:0]           dbgState
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RELAX  = 3'd1,
    EXCITE = 3'd2,
    SAMPLE = 3'd3,
    HOLD   = 3'd4
  } stateE;

  localparam int MAX_CYC = (RELAX_CYCLES > EXCITE_CYCLES) ? RELAX_CYCLES : EXCITE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] RELAX_LAST  = CW'(RELAX_CYCLES - 1);
  localparam logic [CW-1:0] EXCITE_LAST = CW'(EXCITE_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE     = CW'(1);

  stateE                state;
  logic [NUM_CELLS-1:0] sync1;
  logic [NUM_CELLS-1:0] sync2;
  logic [CW-1:0]        cycCnt;
  logic [5:0]           bitCnt;
  logic [31:0]          shiftReg;
  logic                 modeQ;
  logic                 sampleBit;
  logic [31:0]          nextWord;

  assign sampleBit = ^sync2;
  assign nextWord  = {shiftReg[30:0], sampleBit};
  assign dbgState  = state;

  // Handshake: data_valid rises with data_out on the same edge and stays high
  // until a data_read pulse is seen while it is high; data_read while
  // data_valid is low is ignored. No new word starts while data_valid is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
      cycCnt     <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      modeQ      <= 1'b0;
      cell_T     <= 1'b0;
      cell_I1    <= 1'b0;
      cell_I2    <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      sync1 <= cell_out;
      sync2 <= sync1;

      if (data_read && data_valid) data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (en && !data_valid) begin
            state    <= RELAX;
            modeQ    <= mode;
            bitCnt   <= '0;
            shiftReg <= '0;
            cycCnt   <= '0;
            cell_T   <= 1'b0;
            cell_I1  <= 1'b1;
            cell_I2  <= mode;
            busy     <= 1'b1;
          end
        end

        RELAX: begin
          if (!en) begin
            state   <= IDLE;
            cell_T  <= 1'b0;
            cell_I1 <= 1'b0;
            cell_I2 <= 1'b0;
            busy    <= 1'b0;
          end else if (cycCnt == RELAX_LAST) begin
            state  <= EXCITE;
            cycCnt <= '0;
            cell_T <= 1'b1;
          end else begin
            cycCnt <= cycCnt + CYC_ONE;
          end
        end

        EXCITE: begin
          if (!en) begin
            state   <= IDLE;
            cell_T  <= 1'b0;
            cell_I1 <= 1'b0;
            cell_I2 <= 1'b0;
            busy    <= 1'b0;
          end else if (cycCnt == EXCITE_LAST) begin
            state  <= SAMPLE;
            cycCnt <= '0;
          end else begin
            cycCnt <= cycCnt + CYC_ONE;
          end
        end

        SAMPLE: begin
          // The partial word is discarded on disable; shiftReg is cleared at next start.
          if (!en) begin
            state   <= IDLE;
            cell_T  <= 1'b0;
            cell_I1 <= 1'b0;
            cell_I2 <= 1'b0;
            busy    <= 1'b0;
          end else begin
            shiftReg <= nextWord;
            bitCnt   <= bitCnt + 6'd1;
            cell_T   <= 1'b0;
            if (bitCnt == 6'd31) begin
              state      <= HOLD;
              data_out   <= nextWord;
              data_valid <= 1'b1;
              cell_I1    <= 1'b0;
              cell_I2    <= 1'b0;
              busy       <= 1'b0;
            end else begin
              state   <= RELAX;
              cell_I2 <= modeQ;
            end
          end
        end

        HOLD: begin
          if (data_read) state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          cell_T  <= 1'b0;
          cell_I1 <= 1'b0;
          cell_I2 <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// Directed bench for entropy_collector: word assembly, latency, cell drive
// waveforms, mode latching, read handshake, disable and reset mid-word.
module tb_entropy_collector;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        cell_T;
  logic        cell_I1;
  logic        cell_I2;
  logic [3:0]  cellOut;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_read;
  logic        busy;
  logic [2:0]  dbgState;

  int nChecks = 0;
  int nPass   = 0;

  entropy_collector #(
    .NUM_CELLS    (4),
    .RELAX_CYCLES (2),
    .EXCITE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .cell_T    (cell_T),
    .cell_I1   (cell_I1),
    .cell_I2   (cell_I2),
    .cell_out  (cellOut),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_read (data_read),
    .busy      (busy),
    .dbgState  (dbgState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic readPulse();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  // Runs from the edge at which IDLE sees en=1 until data_valid rises.
  // Bit i uses patA when i is even and patB when odd, applied at the rise of cell_T.
  task automatic collect(input logic [3:0] patA, input logic [3:0] patB,
                         input logic i2Exp, input int toggleAt,
                         input logic [31:0] expWord, input string tag);
    int   lat   = 0;
    int   rises = 0;
    int   hiCnt = 0;
    int   loCnt = 0;
    int   badI  = 0;
    logic prevT;
    prevT = cell_T;
    while (lat < 400) begin
      tick();
      lat++;
      if (lat == 1) check({tag, "_busy_start"}, 32'(busy), 32'd1);
      if (data_valid) break;
      if (cell_T && !prevT) begin
        cellOut = rises[0] ? patB : patA;
        rises++;
        if (rises == toggleAt) mode = ~mode;
      end
      prevT = cell_T;
      if (busy) begin
        if (cell_T) hiCnt++;
        else loCnt++;
        if (cell_I2 !== i2Exp) badI++;
      end
      if (cell_I1 !== busy) badI++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd225);
    check({tag, "_word"}, data_out, expWord);
    check({tag, "_bits"}, 32'(rises), 32'd32);
    check({tag, "_t_high"}, 32'(hiCnt), 32'd160);
    check({tag, "_t_low"}, 32'(loCnt), 32'd64);
    check({tag, "_i1_i2"}, 32'(badI), 32'd0);
  endtask

  task automatic runBits(input int nBits, input logic [3:0] pat);
    int   rises = 0;
    int   guard = 0;
    logic prevT;
    prevT = cell_T;
    while (rises < nBits && guard < 300) begin
      tick();
      guard++;
      if (cell_T && !prevT) begin
        cellOut = pat;
        rises++;
      end
      prevT = cell_T;
    end
    check("partial_bits_reached", 32'(rises), 32'(nBits));
  endtask

  initial begin
    int bad;
    rst_n     = 1'b0;
    en        = 1'b0;
    mode      = 1'b1;
    data_read = 1'b0;
    cellOut   = 4'b0000;
    repeat (3) tick();

    check("rst_state", 32'(dbgState), 32'd0);
    check("rst_outputs", {26'd0, cell_T, cell_I1, cell_I2, busy, data_valid, 1'b0}, 32'd0);
    check("rst_data_out", data_out, 32'd0);

    // Constant cell_out with odd parity gives all ones.
    rst_n   = 1'b1;
    mode    = 1'b0;
    cellOut = 4'b0001;
    en      = 1'b1;
    collect(4'b0001, 4'b0001, 1'b0, 0, 32'hFFFF_FFFF, "ones");

    // Unread word must be held with cells idle.
    en  = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (cell_T !== 1'b0 || data_out !== 32'hFFFF_FFFF || data_valid !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("hold_stable", 32'(bad), 32'd0);
    check("hold_state", 32'(dbgState), 32'd4);

    // Read with en high restarts; even parity gives all zeros.
    cellOut = 4'b0011;
    en      = 1'b1;
    readPulse();
    check("read_clears_valid", 32'(data_valid), 32'd0);
    check("read_busy_low", 32'(busy), 32'd0);
    collect(4'b0011, 4'b0011, 1'b0, 0, 32'h0000_0000, "zeros");

    en = 1'b0;
    readPulse();
    check("read_to_idle", 32'(dbgState), 32'd0);
    readPulse();
    tick();
    check("spurious_read_state", 32'(dbgState), 32'd0);
    check("spurious_read_valid", 32'(data_valid), 32'd0);
    check("spurious_read_data", data_out, 32'h0000_0000);

    // Alternating parity, first bit 1.
    mode = 1'b0;
    en   = 1'b1;
    collect(4'b0001, 4'b0000, 1'b0, 0, 32'hAAAA_AAAA, "alt");
    en = 1'b0;
    readPulse();

    // mode latched at word start; toggling mid-word has no effect.
    mode = 1'b1;
    en   = 1'b1;
    collect(4'b0001, 4'b0001, 1'b1, 16, 32'hFFFF_FFFF, "puf");
    readPulse();
    check("mode_after_toggle_i2_idle", 32'(cell_I2), 32'd0);
    collect(4'b0110, 4'b0111, 1'b0, 0, 32'h5555_5555, "rand_after_puf");
    en = 1'b0;
    readPulse();

    // Disable mid-word at bit 20.
    en = 1'b1;
    runBits(20, 4'b0001);
    en = 1'b0;
    tick();
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_state", 32'(dbgState), 32'd0);
    check("drop_cell_T", 32'(cell_T), 32'd0);
    check("drop_valid", 32'(data_valid), 32'd0);
    check("drop_data_kept", data_out, 32'h5555_5555);
    en = 1'b1;
    collect(4'b0001, 4'b0001, 1'b0, 0, 32'hFFFF_FFFF, "reenable");
    en = 1'b0;
    readPulse();

    // Reset during EXCITE of bit 10, then a clean word.
    en = 1'b1;
    runBits(10, 4'b0011);
    tick();
    check("pre_reset_excite", 32'(cell_T), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_outputs", {26'd0, cell_T, cell_I1, cell_I2, busy, data_valid, 1'b0}, 32'd0);
    check("midrst_data_out", data_out, 32'd0);
    check("midrst_state", 32'(dbgState), 32'd0);
    rst_n = 1'b1;
    collect(4'b0001, 4'b0000, 1'b0, 0, 32'hAAAA_AAAA, "after_reset");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
